// File: rtl/decode_pipeline_unit.sv
// Decode-stage register: load-use hazard bubble, taken-branch squash.
// Optional perf counters enabled by defining DECODE_PERF_CNT_EN.
module decode_pipeline_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic        branch_taken,
  input  logic [31:0] ex_instr,
  input  logic        ex_stall,
  output logic [31:0] instr_out,
  output logic        branch_out,
  output logic        stall_fetch
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_squash
`endif
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [31:0] NOP = 32'hE320F000;
  localparam logic [31:0] LDR_MASK = 32'h0C10_0000;
  localparam logic [31:0] LDR_VAL  = 32'h0410_0000;

  typedef enum logic {
    RUN,
    FLUSH
  } state_e;

  state_e      state;
  logic [31:0] dec_q;
  logic [31:0] dec_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic        ex_ldr;
  logic [3:0]  load_rd;
  logic [1:0]  cls;
  logic        use_rn;
  logic        use_rm;
  logic        use_rs;
  logic        hit;
  logic        dec_nop;
  logic        hazard;

  assign state = (cnt_q == '0) ? RUN : FLUSH;

  // Load in execute: class 01 with L bit set
  assign ex_ldr  = (ex_instr & LDR_MASK) == LDR_VAL;
  assign load_rd = ex_instr[15:12];

  assign cls     = dec_q[27:26];
  assign dec_nop = dec_q == NOP;

  always_comb begin
    use_rn = 1'b0;
    use_rm = 1'b0;
    use_rs = 1'b0;
    unique case (cls)
      2'b00: begin
        use_rn = 1'b1;
        use_rm = ~dec_q[25];
        use_rs = ~dec_q[25] & dec_q[4];
      end
      2'b01: begin
        use_rn = 1'b1;
        use_rm = dec_q[25];
      end
      default: begin
      end
    endcase
  end

  assign hit = (use_rn && dec_q[19:16] == load_rd)
            || (use_rm && dec_q[3:0]   == load_rd)
            || (use_rs && dec_q[11:8]  == load_rd);

  assign hazard = ex_ldr & ~dec_nop & hit;

  assign instr_out   = hazard ? NOP : dec_q;
  assign branch_out  = instr_out[27:25] == 3'b101;
  assign stall_fetch = ~branch_taken & (ex_stall | hazard);

  // Cases overlap; earlier items take precedence
  always_comb begin
    dec_d = dec_q;
    cnt_d = cnt_q;
    priority case (1'b1)
      branch_taken: begin
        dec_d = NOP;
        cnt_d = CW'(FLUSH_CYCLES);
      end
      ex_stall: begin
      end
      hazard: begin
      end
      (state == FLUSH): begin
        dec_d = NOP;
        cnt_d = cnt_q - 1'b1;
      end
      default: dec_d = instr_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q <= NOP;
      cnt_q <= '0;
    end else begin
      dec_q <= dec_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic stall_inc;
  logic squash_inc;

  assign stall_inc = hazard & ~ex_stall & ~branch_taken;
  assign squash_inc = branch_taken ? ~dec_nop
                    : (~ex_stall & ~hazard & (state == FLUSH));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall  <= '0;
      perf_squash <= '0;
    end else begin
      if (stall_inc && !(&perf_stall))
        perf_stall <= perf_stall + 1'b1;
      if (squash_inc && !(&perf_squash))
        perf_squash <= perf_squash + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_pipeline_unit.sv
// Scoreboard bench for decode_pipeline_unit: directed cases then random traffic.
// Execute stage is modelled in the bench and feeds ex_instr.
module tb_decode_pipeline_unit;

  localparam int FLUSH_CYCLES = 2;
  localparam int PERF_W = 16;
  localparam int PMAX = (1 << PERF_W) - 1;
  localparam logic [31:0] NOP = 32'hE320F000;

  logic        clk;
  logic        rst;
  logic [31:0] instr_in;
  logic        branch_taken;
  logic [31:0] ex_instr;
  logic        ex_stall;
  logic [31:0] instr_out;
  logic        branch_out;
  logic        stall_fetch;
`ifdef DECODE_PERF_CNT_EN
  logic [PERF_W-1:0] perf_stall;
  logic [PERF_W-1:0] perf_squash;
`endif

  decode_pipeline_unit #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .PERF_W(PERF_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .instr_in(instr_in),
    .branch_taken(branch_taken),
    .ex_instr(ex_instr),
    .ex_stall(ex_stall),
    .instr_out(instr_out),
    .branch_out(branch_out),
    .stall_fetch(stall_fetch)
`ifdef DECODE_PERF_CNT_EN
    ,
    .perf_stall(perf_stall),
    .perf_squash(perf_squash)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] io;
    logic        bo;
    logic        sf;
    int          ps;
    int          pq;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_dec = NOP;
  logic [31:0] m_ex = NOP;
  int  m_squash_left = 0;
  int  m_ps = 0;
  int  m_pq = 0;
  bit  m_known = 0;

  function automatic int sat(input int v);
    return (v > PMAX) ? PMAX : v;
  endfunction

  function automatic bit reads_reg(input logic [31:0] i, input logic [3:0] r);
    logic [3:0] src[$];
    case (i[27:26])
      2'b00: begin
        src.push_back(i[19:16]);
        if (!i[25]) begin
          src.push_back(i[3:0]);
          if (i[4]) src.push_back(i[11:8]);
        end
      end
      2'b01: begin
        src.push_back(i[19:16]);
        if (i[25]) src.push_back(i[3:0]);
      end
      default: ;
    endcase
    foreach (src[k]) if (src[k] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_load(input logic [31:0] i);
    return (i[27:26] == 2'b01) && i[20];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents its outputs every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("instr_out", instr_out, e.io);
        chk("branch_out", {31'd0, branch_out}, {31'd0, e.bo});
        chk("stall_fetch", {31'd0, stall_fetch}, {31'd0, e.sf});
`ifdef DECODE_PERF_CNT_EN
        chk("perf_stall", 32'(perf_stall), 32'(e.ps));
        chk("perf_squash", 32'(perf_squash), 32'(e.pq));
`endif
      end
    end
  end

  // Drive one cycle at posedge+1, push expectation, then advance the model.
  task automatic cycle(input logic r, input logic [31:0] ins,
                       input logic b, input logic s);
    exp_t e;
    bit haz;
    logic [31:0] out;
    rst = r;
    instr_in = ins;
    branch_taken = b;
    ex_stall = s;
    ex_instr = m_ex;
    haz = is_load(m_ex) && (m_dec != NOP) && reads_reg(m_dec, m_ex[15:12]);
    out = haz ? NOP : m_dec;
    e.io = out;
    e.bo = (out[27:24] == 4'hA) || (out[27:24] == 4'hB);
    e.sf = !b && (s || haz);
    e.ps = m_ps;
    e.pq = m_pq;
    if (m_known) sb.push_back(e);
    @(posedge clk);
    if (r) begin
      m_dec = NOP;
      m_ex = NOP;
      m_squash_left = 0;
      m_ps = 0;
      m_pq = 0;
      m_known = 1;
    end else begin
      if (!s) m_ex = out;
      if (b) begin
        if (m_dec != NOP) m_pq = sat(m_pq + 1);
        m_dec = NOP;
        m_squash_left = FLUSH_CYCLES;
      end else if (s) begin
      end else if (haz) begin
        m_ps = sat(m_ps + 1);
      end else if (m_squash_left > 0) begin
        m_dec = NOP;
        m_squash_left--;
        m_pq = sat(m_pq + 1);
      end else begin
        m_dec = ins;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;
    logic [3:0] rs;
    logic [23:0] off;
    rn = 4'($urandom_range(0, 3));
    rd = 4'($urandom_range(0, 3));
    rm = 4'($urandom_range(0, 3));
    rs = 4'($urandom_range(0, 3));
    off = 24'($urandom);
    case ($urandom_range(0, 9))
      0, 1: return {12'hE08, rn, rd, 8'h00, rm};
      2:    return {12'hE08, rn, rd, rs, 4'h1, rm};
      3, 4: return {12'hE59, rn, rd, 12'h000};
      5:    return {12'hE58, rn, rd, 12'h000};
      6:    return {12'hE79, rn, rd, 8'h00, rm};
      7:    return {8'hEA, off};
      8:    return NOP;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    instr_in = 32'hE0813004;
    branch_taken = 1'b0;
    ex_stall = 1'b0;
    ex_instr = NOP;
    #1;
    // Reset for two cycles
    cycle(1, 32'hE0813004, 0, 0);
    cycle(1, 32'hE0813004, 0, 0);
    // Load-use: LDR r1,[r2] then ADD r3,r1,r4
    cycle(0, 32'hE5921000, 0, 0);
    cycle(0, 32'hE0813004, 0, 0);
    cycle(0, 32'hE0813004, 0, 0);
    cycle(0, NOP, 0, 0);
    cycle(0, NOP, 0, 0);
    // No false hazard: ADD r4,r5,r6 after LDR r1
    cycle(0, 32'hE5921000, 0, 0);
    cycle(0, 32'hE0854006, 0, 0);
    cycle(0, NOP, 0, 0);
    cycle(0, NOP, 0, 0);
    // Branch flush with A,B,C,T stream
    cycle(0, 32'hE0811002, 0, 0);
    cycle(0, 32'hE0822003, 1, 0);
    cycle(0, 32'hE0833004, 0, 0);
    cycle(0, 32'hE0844005, 0, 0);
    cycle(0, 32'hEA000010, 0, 0);
    cycle(0, NOP, 0, 0);
    cycle(0, NOP, 0, 0);
    // ex_stall held three cycles
    cycle(0, 32'hE0811002, 0, 0);
    cycle(0, 32'hE0822003, 0, 1);
    cycle(0, 32'hE0822003, 0, 1);
    cycle(0, 32'hE0822003, 0, 1);
    cycle(0, 32'hE0822003, 0, 0);
    cycle(0, NOP, 0, 0);
    // Branch in the same cycle as a hazard
    cycle(0, 32'hE5921000, 0, 0);
    cycle(0, 32'hE0813004, 0, 0);
    cycle(0, 32'hE0813004, 1, 0);
    cycle(0, 32'hE0000001, 0, 0);
    cycle(0, 32'hE0000002, 0, 0);
    cycle(0, 32'hE0000003, 0, 0);
    // Branch during an active flush restarts it
    cycle(0, 32'hE0811002, 1, 0);
    cycle(0, 32'hE0811002, 0, 0);
    cycle(0, 32'hE0811002, 1, 0);
    cycle(0, 32'hE0811002, 0, 0);
    cycle(0, 32'hE0811002, 0, 0);
    cycle(0, 32'hE0811002, 0, 0);
    // Reset in the middle of a flush
    cycle(0, 32'hE0822003, 1, 0);
    cycle(1, 32'hE0822003, 0, 0);
    cycle(0, 32'hE0833004, 0, 0);
    cycle(0, NOP, 0, 0);
    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 199) == 0), rand_instr(),
            ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 12));
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
